data_array_mp: RTL and testbench
================================

// Module: data_array_mp
// PURPOSE
//  Next-generation banked I-cache data array: NUM_WAYS x NUM_BANKS single-ported banks.
//  - Parametric read-port count, each port with a valid/ready handshake.
//  - Per-bank conflict arbitration between ports; write port has byte enables.
//  - Reads have 1-cycle registered latency.
//  - Sits between the fetch pipeline (read ports, one per fetched line) and the refill unit (write port).
// PARAMETERS
//  NUM_WAYS            4    ways per set
//  NUM_BANKS           4    banks (power of 2); BSW = $clog2(NUM_BANKS)
//  SETS_PER_BANK_WIDTH 8    set-index width per bank (256 sets)
//  BLOCK_WIDTH         512  line width in bits (multiple of 8); NBYTES = BLOCK_WIDTH/8
//  NUM_RPORTS          2    read ports (>=1)
// PORTS
//  clk_i          in   1                        clock
//  rst_ni         in   1                        async active-low reset
//  rd_valid_i     in   NUM_RPORTS               read request valid, per port
//  rd_ready_o     out  NUM_RPORTS               request accepted this cycle
//  rd_addr_i      in   NUM_RPORTS*SETS_PER_BANK_WIDTH  set index, per port
//  rd_bank_i      in   NUM_RPORTS*BSW           bank select, per port
//  rd_rvalid_o    out  NUM_RPORTS               read data valid (1 cycle after accept)
//  rd_rdata_o     out  NUM_RPORTS*NUM_WAYS*BLOCK_WIDTH  all ways of the addressed set
//  rd_perr_o      out  NUM_RPORTS*NUM_WAYS      parity error per way (see CONFIGURATION)
//  wr_valid_i     in   1                        write request valid
//  wr_ready_o     out  1                        always 1 (write never stalls)
//  wr_addr_i      in   SETS_PER_BANK_WIDTH      write set index
//  wr_bank_i      in   BSW                      write bank
//  wr_way_mask_i  in   NUM_WAYS                 ways written (one-hot or multi-hot)
//  wr_be_i        in   NBYTES                   byte enables
//  wr_data_i      in   BLOCK_WIDTH              write data, same for all selected ways
// BEHAVIOUR
//  Storage
//  - Each bank performs one access per cycle: a read of one set, or a write.
//  - Contents are not reset.
//  Arbitration (combinational, per bank)
//  - Write has absolute priority: if wr_valid_i targets bank b, every read to b gets ready=0.
//  - Reads to the same bank and same set index merge: all such ports get ready=1.
//  - Reads to the same bank with different sets: one winner chosen by round-robin pointer rr_q.
//    - Priority order: rr_q, rr_q+1, ... mod NUM_RPORTS. Losers get ready=0.
//    - rr_q advances to (winner+1) mod NUM_RPORTS only in cycles with such a loss.
//  - rd_ready_o[p] is 0 whenever rd_valid_i[p] is 0.
//  Read path
//  - Accept at edge N: rd_rvalid_o[p]=1 during cycle N+1, with rd_rdata_o[p] = array contents before edge N's write.
//  - rd_rdata_o holds its last value while rd_rvalid_o=0.
//  Write path
//  - On edge with wr_valid_i: for each way w with wr_way_mask_i[w], byte k is updated iff wr_be_i[k].
//  - wr_way_mask_i=0 or wr_be_i=0: no state change.
//  Boundaries
//  - Write and read to different banks in one cycle: both proceed.
//  - Back-to-back reads on all ports: throughput 1/cycle per port when there are no conflicts.
//  - Bank index wraps naturally. NUM_RPORTS=1: rr_q is a constant 0.
//  Reset (async assert, sync deassert by system)
//  - rd_rvalid_o=0, rd_rdata_o=0, rd_perr_o=0, rr_q=0.
//  - A read accepted in the cycle reset asserts produces no rd_rvalid_o.
// CONFIGURATION
//  DATA_ARRAY_PARITY_EN defined:
//  - One even-parity bit is stored per byte per way, updated only for enabled bytes.
//  - On read, parity is recomputed. rd_perr_o[p][w]=1 (qualified by rd_rvalid_o[p]) if any byte of way w mismatches.
//  - Parity storage is not reset: tests write before reading.
//  DATA_ARRAY_PARITY_EN undefined:
//  - No parity storage. rd_perr_o is tied to 0; the port exists in both builds.
// TESTING
//  1. Reset, write bank1 set5 way2 all-BE data=A5..A5; read p0 bank1 set5 next cycle
//     -> rvalid one cycle after accept; way2=A5..A5.
//  2. Partial write wr_be_i=0x...0001 data=FF..FF over A5..A5
//     -> read gives byte0=FF, other bytes A5.
//  3. p0 and p1 both read bank2, sets 3 and 7, rr_q=0
//     -> p0 ready, p1 stalled, rr_q=1; next cycle p1 wins.
//  4. p0 and p1 both read bank0 set 9 -> both ready; identical rdata next cycle.
//  5. Write bank3 with p0 read bank3 and p1 read bank0 in the same cycle
//     -> p0 ready=0, p1 ready=1; after the write, p0 reads the new data.
//  6. PARITY_EN: force-flip one stored bit of way1 via hierarchical deposit, then read
//     -> rd_perr_o[p][1]=1, others 0. Reset mid-read -> rd_rvalid_o stays 0.

Source files
------------

// File: rtl/data_array_mp.sv
// Banked multi-read-port I-cache data array with per-bank arbitration and a byte-enabled refill write port.
// Optional per-byte even parity is enabled by defining DATA_ARRAY_PARITY_EN.
module data_array_mp #(
    parameter int NUM_WAYS            = 4,
    parameter int NUM_BANKS           = 4,
    parameter int SETS_PER_BANK_WIDTH = 8,
    parameter int BLOCK_WIDTH         = 512,
    parameter int NUM_RPORTS          = 2,
    localparam int BSW                = $clog2(NUM_BANKS),
    localparam int NBYTES             = BLOCK_WIDTH / 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NUM_RPORTS-1:0]                       rd_valid_i,
    output logic [NUM_RPORTS-1:0]                       rd_ready_o,
    input  logic [NUM_RPORTS*SETS_PER_BANK_WIDTH-1:0]   rd_addr_i,
    input  logic [NUM_RPORTS*BSW-1:0]                   rd_bank_i,
    output logic [NUM_RPORTS-1:0]                       rd_rvalid_o,
    output logic [NUM_RPORTS*NUM_WAYS*BLOCK_WIDTH-1:0]  rd_rdata_o,
    output logic [NUM_RPORTS*NUM_WAYS-1:0]              rd_perr_o,
    input  logic                                        wr_valid_i,
    output logic                                        wr_ready_o,
    input  logic [SETS_PER_BANK_WIDTH-1:0]              wr_addr_i,
    input  logic [BSW-1:0]                              wr_bank_i,
    input  logic [NUM_WAYS-1:0]                         wr_way_mask_i,
    input  logic [NBYTES-1:0]                           wr_be_i,
    input  logic [BLOCK_WIDTH-1:0]                      wr_data_i
);

    localparam int NSETS = 1 << SETS_PER_BANK_WIDTH;
    localparam int RRW   = (NUM_RPORTS > 1) ? $clog2(NUM_RPORTS) : 1;

    logic [BLOCK_WIDTH-1:0]         mem_q [NUM_BANKS][NSETS][NUM_WAYS];
    logic [SETS_PER_BANK_WIDTH-1:0] raddr [NUM_RPORTS];
    logic [BSW-1:0]                 rbank [NUM_RPORTS];
    logic [NUM_RPORTS-1:0]          ready;
    logic [RRW-1:0]                 rr_q;
    logic [RRW-1:0]                 rr_d;
    logic                           loss;
    logic [NUM_WAYS-1:0]            perr_d [NUM_RPORTS];

    logic [NUM_RPORTS-1:0]                      vld_p1;
    logic [NUM_RPORTS*NUM_WAYS*BLOCK_WIDTH-1:0] rdata_p1;
    logic [NUM_RPORTS*NUM_WAYS-1:0]             perr_p1;

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            raddr[p] = rd_addr_i[p*SETS_PER_BANK_WIDTH +: SETS_PER_BANK_WIDTH];
            rbank[p] = rd_bank_i[p*BSW +: BSW];
        end
    end

    // Each port looks up the round-robin winner of its own bank; ports sharing the
    // winner's set ride along, the rest stall. Only the first losing bank moves rr.
    always_comb begin : arb_comb
        int  win;
        int  idx;
        logic found;
        ready = '0;
        rr_d  = rr_q;
        loss  = 1'b0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            win   = p;
            found = 1'b0;
            for (int k = 0; k < NUM_RPORTS; k++) begin
                idx = (int'(rr_q) + k) % NUM_RPORTS;
                if (!found && rd_valid_i[idx] && (rbank[idx] == rbank[p])) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
            if (rd_valid_i[p] && !(wr_valid_i && (wr_bank_i == rbank[p]))) begin
                if (raddr[win] == raddr[p]) begin
                    ready[p] = 1'b1;
                end else if (!loss) begin
                    loss = 1'b1;
                    rr_d = RRW'((win + 1) % NUM_RPORTS);
                end
            end
        end
    end

    assign rd_ready_o = ready;
    assign wr_ready_o = 1'b1;

    always_ff @(posedge clk_i) begin
        if (wr_valid_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (wr_way_mask_i[w] && wr_be_i[k]) begin
                        mem_q[wr_bank_i][wr_addr_i][w][k*8 +: 8] <= wr_data_i[k*8 +: 8];
                    end
                end
            end
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [NBYTES-1:0] par_q [NUM_BANKS][NSETS][NUM_WAYS];

    function automatic logic [NBYTES-1:0] byte_parity(input logic [BLOCK_WIDTH-1:0] d);
        logic [NBYTES-1:0] r;
        for (int k = 0; k < NBYTES; k++) begin
            r[k] = ^d[k*8 +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (wr_valid_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (wr_way_mask_i[w] && wr_be_i[k]) begin
                        par_q[wr_bank_i][wr_addr_i][w][k] <= ^wr_data_i[k*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                perr_d[p][w] = |(byte_parity(mem_q[rbank[p]][raddr[p]][w]) ^
                                 par_q[rbank[p]][raddr[p]][w]);
            end
        end
    end
`else
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            perr_d[p] = '0;
        end
    end
`endif

    // Stage p1: registered read data, one cycle after accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            vld_p1   <= '0;
            rdata_p1 <= '0;
            perr_p1  <= '0;
        end else begin
            rr_q   <= rr_d;
            vld_p1 <= ready;
            for (int p = 0; p < NUM_RPORTS; p++) begin
                if (ready[p]) begin
                    for (int w = 0; w < NUM_WAYS; w++) begin
                        rdata_p1[(p*NUM_WAYS + w)*BLOCK_WIDTH +: BLOCK_WIDTH] <=
                            mem_q[rbank[p]][raddr[p]][w];
                    end
                    perr_p1[p*NUM_WAYS +: NUM_WAYS] <= perr_d[p];
                end
            end
        end
    end

    assign rd_rvalid_o = vld_p1;
    assign rd_rdata_o  = rdata_p1;

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd_perr_o[p*NUM_WAYS +: NUM_WAYS] = perr_p1[p*NUM_WAYS +: NUM_WAYS] & {NUM_WAYS{vld_p1[p]}};
        end
    end

endmodule

// File: tb/tb_data_array_mp.sv
// Table-driven bench for data_array_mp with a shadow-memory scoreboard for read data.
module tb_data_array_mp;

    localparam int NW = 4;
    localparam int BW = 512;
    localparam int LW = NW * BW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      rd_valid, rd_ready, rd_rvalid;
    logic [15:0]     rd_addr;
    logic [3:0]      rd_bank;
    logic [2*LW-1:0] rd_rdata;
    logic [7:0]      rd_perr;
    logic            wr_valid, wr_ready;
    logic [7:0]      wr_addr;
    logic [1:0]      wr_bank;
    logic [3:0]      wr_way_mask;
    logic [63:0]     wr_be;
    logic [BW-1:0]   wr_data;

    data_array_mp dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr), .rd_bank_i(rd_bank),
        .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata), .rd_perr_o(rd_perr),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_bank_i(wr_bank),
        .wr_way_mask_i(wr_way_mask), .wr_be_i(wr_be), .wr_data_i(wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  rb0;
        logic [7:0]  ra0;
        logic [1:0]  rb1;
        logic [7:0]  ra1;
        logic        wv;
        logic [1:0]  wb;
        logic [7:0]  wa;
        logic [3:0]  wm;
        logic [63:0] be;
        logic [7:0]  wd;
        logic [1:0]  rdy;
    } vec_t;

    vec_t            vecs[$];
    logic [BW-1:0]   sh[int];
    logic [LW-1:0]   q0[$];
    logic [LW-1:0]   q1[$];
    logic [LW-1:0]   last_d[2];
    logic [1:0]      pend;
    logic [3:0]      exp_perr[2];
    int              checks = 0;
    int              failures = 0;

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] rb0, input logic [7:0] ra0,
                                input logic [1:0] rb1, input logic [7:0] ra1, input logic wv,
                                input logic [1:0] wb, input logic [7:0] wa, input logic [3:0] wm,
                                input logic [63:0] be, input logic [7:0] wd, input logic [1:0] rdy);
        vec_t v;
        v.rv = rv; v.rb0 = rb0; v.ra0 = ra0; v.rb1 = rb1; v.ra1 = ra1;
        v.wv = wv; v.wb = wb; v.wa = wa; v.wm = wm; v.be = be; v.wd = wd; v.rdy = rdy;
        return v;
    endfunction

    function automatic vec_t rd(input logic [1:0] rv, input logic [1:0] rb0, input logic [7:0] ra0,
                                input logic [1:0] rb1, input logic [7:0] ra1, input logic [1:0] rdy);
        return mk(rv, rb0, ra0, rb1, ra1, 1'b0, 2'd0, 8'd0, 4'd0, 64'd0, 8'd0, rdy);
    endfunction

    function automatic int key(input int b, input int s, input int w);
        return b * 1024 + s * 4 + w;
    endfunction

    function automatic logic [LW-1:0] exp_line(input int b, input int s);
        logic [LW-1:0] l;
        l = '0;
        for (int w = 0; w < NW; w++) begin
            if (sh.exists(key(b, s, w))) l[w*BW +: BW] = sh[key(b, s, w)];
        end
        return l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic chk_line(input string nm, input int p, input logic [LW-1:0] a, input logic [LW-1:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            for (int w = NW - 1; w >= 0; w--) begin
                if (a[w*BW +: BW] !== e[w*BW +: BW])
                    $display("FAIL %s port%0d way%0d got=%h exp=%h", nm, p, w, a[w*BW +: BW], e[w*BW +: BW]);
            end
        end
    endtask

    task automatic check_out();
        logic [LW-1:0] e;
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rvalid%0d", p), 32'(rd_rvalid[p]), 32'd1);
                chk_line("rdata", p, rd_rdata[p*LW +: LW], e);
                chk($sformatf("perr%0d", p), 32'(rd_perr[p*NW +: NW]), 32'(exp_perr[p]));
                last_d[p] = e;
            end else begin
                chk($sformatf("rvalid%0d_idle", p), 32'(rd_rvalid[p]), 32'd0);
                chk_line("rdata_hold", p, rd_rdata[p*LW +: LW], last_d[p]);
                chk($sformatf("perr%0d_idle", p), 32'(rd_perr[p*NW +: NW]), 32'd0);
            end
        end
    endtask

    task automatic step(input vec_t v);
        logic [BW-1:0] tmp;
        rd_valid    = v.rv;
        rd_addr     = {v.ra1, v.ra0};
        rd_bank     = {v.rb1, v.rb0};
        wr_valid    = v.wv;
        wr_bank     = v.wb;
        wr_addr     = v.wa;
        wr_way_mask = v.wm;
        wr_be       = v.be;
        wr_data     = {64{v.wd}};
        #3;
        check_out();
        chk("ready", 32'(rd_ready), 32'(v.rdy));
        chk("wr_ready", 32'(wr_ready), 32'd1);
        pend = v.rdy & v.rv;
        if (pend[0]) q0.push_back(exp_line(v.rb0, v.ra0));
        if (pend[1]) q1.push_back(exp_line(v.rb1, v.ra1));
        if (v.wv) begin
            for (int w = 0; w < NW; w++) begin
                if (v.wm[w]) begin
                    tmp = sh.exists(key(v.wb, v.wa, w)) ? sh[key(v.wb, v.wa, w)] : '0;
                    for (int i = 0; i < 64; i++) if (v.be[i]) tmp[i*8 +: 8] = v.wd;
                    sh[key(v.wb, v.wa, w)] = tmp;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] ALL = '1;

    initial begin
        rst_n = 1'b0; rd_valid = '0; rd_addr = '0; rd_bank = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_bank = '0; wr_way_mask = '0; wr_be = '0; wr_data = '0;
        pend = '0; last_d[0] = '0; last_d[1] = '0; exp_perr[0] = '0; exp_perr[1] = '0;

        @(posedge clk); #1;
        chk("rst_rvalid", 32'(rd_rvalid), 32'd0);
        chk_line("rst_rdata", 0, rd_rdata[0 +: LW], '0);
        chk_line("rst_rdata", 1, rd_rdata[LW +: LW], '0);
        chk("rst_perr", 32'(rd_perr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //          rv    rb0  ra0   rb1  ra1   wv  wb   wa    wm       be     wd     rdy
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 1, 5,  4'b1111, ALL,   8'h00, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 1, 5,  4'b0100, ALL,   8'hA5, 2'b00));
        vecs.push_back(rd(2'b01, 1, 5,    0, 0,    2'b01));
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 1, 5,  4'b0100, 64'd1, 8'hFF, 2'b00));
        vecs.push_back(rd(2'b01, 1, 5,    0, 0,    2'b01));
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 2, 3,  4'b1111, ALL,   8'h11, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 2, 7,  4'b1111, ALL,   8'h22, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 0, 9,  4'b1111, ALL,   8'h33, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,    0, 0,    1, 3, 4,  4'b1111, ALL,   8'h40, 2'b00));
        vecs.push_back(rd(2'b11, 2, 3,    2, 7,    2'b01));
        vecs.push_back(rd(2'b11, 2, 3,    2, 7,    2'b10));
        vecs.push_back(rd(2'b11, 0, 9,    0, 9,    2'b11));
        vecs.push_back(mk(2'b11, 3, 4,    0, 9,    1, 3, 4,  4'b1111, ALL,   8'h44, 2'b10));
        vecs.push_back(rd(2'b01, 3, 4,    0, 0,    2'b01));
        vecs.push_back(mk(2'b10, 0, 0,    3, 4,    1, 0, 9,  4'b0000, ALL,   8'h55, 2'b10));
        vecs.push_back(rd(2'b01, 0, 9,    0, 0,    2'b01));
        vecs.push_back(mk(2'b01, 2, 3,    0, 0,    1, 1, 5,  4'b1111, 64'd0, 8'h66, 2'b01));
        vecs.push_back(rd(2'b11, 1, 5,    2, 3,    2'b11));
        vecs.push_back(rd(2'b11, 2, 3,    2, 3,    2'b11));
        vecs.push_back(rd(2'b11, 2, 3,    2, 7,    2'b01));
        vecs.push_back(rd(2'b11, 2, 3,    2, 7,    2'b10));
        vecs.push_back(rd(2'b00, 0, 0,    0, 0,    2'b00));
        vecs.push_back(rd(2'b11, 0, 9,    1, 5,    2'b11));
        vecs.push_back(rd(2'b11, 1, 5,    0, 9,    2'b11));
        vecs.push_back(rd(2'b11, 3, 4,    2, 7,    2'b11));
        vecs.push_back(rd(2'b00, 0, 0,    0, 0,    2'b00));
        vecs.push_back(mk(2'b11, 2, 7,    2, 3,    1, 2, 3,  4'b0001, ALL,   8'h77, 2'b00));
        vecs.push_back(rd(2'b10, 0, 0,    2, 3,    2'b10));
        vecs.push_back(rd(2'b11, 2, 3,    2, 7,    2'b01));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset asserted while a read is being accepted; rr must also return to 0.
        rd_valid = 2'b01; rd_bank = {2'd0, 2'd0}; rd_addr = {8'd0, 8'd9};
        wr_valid = 1'b0;
        #3;
        check_out();
        chk("ready_pre_rst", 32'(rd_ready), 32'd1);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_rvalid", 32'(rd_rvalid), 32'd0);
        chk_line("mid_rst_rdata", 0, rd_rdata[0 +: LW], '0);
        rd_valid = '0;
        rst_n = 1'b1;
        pend = '0; last_d[0] = '0; last_d[1] = '0;
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        step(rd(2'b11, 2, 3, 2, 7, 2'b01));
        step(rd(2'b00, 0, 0, 0, 0, 2'b00));

`ifdef DATA_ARRAY_PARITY_EN
        step(mk(2'b00, 0, 0, 0, 0, 1, 1, 6, 4'b1111, ALL, 8'h5A, 2'b00));
        dut.mem_q[1][6][1][3] = ~dut.mem_q[1][6][1][3];
        sh[key(1, 6, 1)][3] = ~sh[key(1, 6, 1)][3];
        step(rd(2'b10, 0, 0, 1, 6, 2'b10));
        exp_perr[1] = 4'b0010;
        step(rd(2'b00, 0, 0, 0, 0, 2'b00));
        exp_perr[1] = 4'b0000;
`endif

        step(rd(2'b00, 0, 0, 0, 0, 2'b00));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
